rd_cmp: RTL and testbench

- Read-side comparator of the memory checker, and the consumer end of the compare FIFO.
- Pops expected-data entries (cmp_struct_t) from the FIFO.
- Pairs each entry in order with a read-data beat returned by memory.
- Compares under byte mask and accumulates statistics: compare count, error count, sticky error flag, first-error capture, underflow flag.

---
 rtl/mem_checker_pkg.sv | 25 ++
 rtl/rd_cmp_prefetch.sv | 52 +++++
 rtl/rd_cmp.sv | 115 +++++++++++
 tb/tb_rd_cmp.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_checker_pkg.sv
// Shared types for the memory checker: compare-FIFO entry layout and the
// byte-enable expansion helper used by the read-side comparator.
package mem_checker_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } cmp_struct_t;

  // Replicate each byte-enable bit across its 8 data bits.
  function automatic logic [DATA_W-1:0] be_expand(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rd_cmp_prefetch.sv
// Entry prefetch for rd_cmp: hides the 1-cycle FIFO read latency with a
// one-deep holding register so that one expected entry can be paired with a
// read beat every cycle.
module rd_cmp_prefetch
  import mem_checker_pkg::*;
(
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rdreq_o,
  input  cmp_struct_t fifo_q_i,
  input  logic        rd_data_valid_i,
  output cmp_struct_t head_o,
  output logic        avail_o,
  output logic        consume_o
);

  logic        pend;
  logic        cur_v;
  cmp_struct_t cur;

  // pend: fifo_q_i carries a freshly popped entry this cycle.
  // cur_v: an entry is parked in cur. The two are never both set.
  assign avail_o      = pend | cur_v;
  assign head_o       = cur_v ? cur : fifo_q_i;
  assign consume_o    = rd_data_valid_i & avail_o;
  // Gated by reset so no pop is issued while the FIFO is being reset too.
  assign fifo_rdreq_o = srst_n_i & ~fifo_empty_i & (~avail_o | consume_o);

  // Track outstanding pop and holding-register occupancy.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      pend  <= 1'b0;
      cur_v <= 1'b0;
    end else begin
      pend <= fifo_rdreq_o;
      if (pend && !consume_o) begin
        cur_v <= 1'b1;
      end else if (consume_o) begin
        cur_v <= 1'b0;
      end
    end
  end

  // Park a popped entry that was not consumed on arrival.
  always_ff @(posedge clk_i) begin
    if (pend && !consume_o) begin
      cur <= fifo_q_i;
    end
  end

endmodule

// File: rtl/rd_cmp.sv
// Read-side comparator of the memory checker. Pairs expected entries from the
// compare FIFO with returned read beats, compares under byte mask and keeps
// saturating statistics. Optional macro RD_CMP_ERR_DATA_EN enables capture of
// the first mismatching read data on first_err_data_o (otherwise tied to 0).
module rd_cmp
  import mem_checker_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  input  cmp_struct_t       fifo_q_i,
  input  logic              rd_data_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              start_i,
  output logic [CNT_W-1:0]  cmp_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] first_err_data_o,
  output logic              underflow_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  cmp_struct_t head;
  logic        avail;
  logic        consume;

  rd_cmp_prefetch u_prefetch (
    .clk_i           (clk_i),
    .srst_n_i        (srst_n_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rdreq_o    (fifo_rdreq_o),
    .fifo_q_i        (fifo_q_i),
    .rd_data_valid_i (rd_data_valid_i),
    .head_o          (head),
    .avail_o         (avail),
    .consume_o       (consume)
  );

  // Stage 1: register the consumed beat and its expected entry.
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] rd_p1;
  logic [DATA_W-1:0] exp_p1;
  logic [BE_W-1:0]   be_p1;

  // S1 valid; start discards a beat already in flight.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i || start_i) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= consume;
    end
  end

  // S1 data, loaded only when a beat is paired with an entry.
  always_ff @(posedge clk_i) begin
    if (consume) begin
      addr_p1 <= head.addr;
      rd_p1   <= rd_data_i;
      exp_p1  <= head.data;
      be_p1   <= head.be;
    end
  end

  // Stage 2: masked compare; an all-zero byte enable can never mismatch.
  logic mismatch_p2;
  assign mismatch_p2 = |((rd_p1 ^ exp_p1) & be_expand(be_p1));

  // Statistics; start wins over a same-cycle update.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i || start_i) begin
      cmp_cnt_o        <= '0;
      err_cnt_o        <= '0;
      err_o            <= 1'b0;
      first_err_addr_o <= '0;
      underflow_o      <= 1'b0;
    end else begin
      if (rd_data_valid_i && !avail) begin
        underflow_o <= 1'b1;
      end
      if (vld_p1) begin
        cmp_cnt_o <= sat_inc(cmp_cnt_o);
        if (mismatch_p2) begin
          err_cnt_o <= sat_inc(err_cnt_o);
          err_o     <= 1'b1;
          if (!err_o) begin
            first_err_addr_o <= addr_p1;
          end
        end
      end
    end
  end

`ifdef RD_CMP_ERR_DATA_EN
  // Capture read data of the first mismatch.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i || start_i) begin
      first_err_data_o <= '0;
    end else if (vld_p1 && mismatch_p2 && !err_o) begin
      first_err_data_o <= rd_p1;
    end
  end
`else
  assign first_err_data_o = '0;
`endif

endmodule

// File: tb/tb_rd_cmp.sv
// Scoreboard bench for rd_cmp: directed beats push expected statistics into a
// queue; a monitor pops and compares two edges after each beat. A second
// instance with CNT_W=4 shares all inputs to exercise counter saturation.
module tb_rd_cmp;
  import mem_checker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              srst_n;
  logic              fifo_empty;
  logic              fifo_rdreq;
  logic              fifo_rdreq_s;
  cmp_struct_t       fifo_q;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              start;

  logic [31:0]       cmp_cnt, err_cnt;
  logic              err_f, uf;
  logic [ADDR_W-1:0] fe_addr;
  logic [DATA_W-1:0] fe_data;

  logic [3:0]        s_cmp_cnt, s_err_cnt;
  logic              s_err_f, s_uf;
  logic [ADDR_W-1:0] s_fe_addr;
  logic [DATA_W-1:0] s_fe_data;

  rd_cmp #(.CNT_W(32)) dut (
    .clk_i(clk), .srst_n_i(srst_n), .fifo_empty_i(fifo_empty),
    .fifo_rdreq_o(fifo_rdreq), .fifo_q_i(fifo_q), .rd_data_valid_i(rd_valid),
    .rd_data_i(rd_data), .start_i(start), .cmp_cnt_o(cmp_cnt),
    .err_cnt_o(err_cnt), .err_o(err_f), .first_err_addr_o(fe_addr),
    .first_err_data_o(fe_data), .underflow_o(uf)
  );

  rd_cmp #(.CNT_W(4)) dut_s (
    .clk_i(clk), .srst_n_i(srst_n), .fifo_empty_i(fifo_empty),
    .fifo_rdreq_o(fifo_rdreq_s), .fifo_q_i(fifo_q), .rd_data_valid_i(rd_valid),
    .rd_data_i(rd_data), .start_i(start), .cmp_cnt_o(s_cmp_cnt),
    .err_cnt_o(s_err_cnt), .err_o(s_err_f), .first_err_addr_o(s_fe_addr),
    .first_err_data_o(s_fe_data), .underflow_o(s_uf)
  );

  // Compare FIFO model: 1-cycle registered read, push request from stimulus.
  cmp_struct_t fifo_mem[$];
  logic        push_v;
  cmp_struct_t push_e;
  always @(posedge clk) begin
    if (!srst_n) begin
      fifo_mem.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rdreq) fifo_q <= fifo_mem.pop_front();
      if (push_v) fifo_mem.push_back(push_e);
      fifo_empty <= (fifo_mem.size() == 0);
    end
  end

  typedef struct {
    logic [31:0] cmp;
    logic [31:0] err;
    logic        errf;
    logic [31:0] addr;
    logic [31:0] data;
    logic        uf;
    logic [3:0]  scmp;
    logic [3:0]  serr;
  } snap_t;

  snap_t       exp_q[$];
  cmp_struct_t m_q[$];
  snap_t       ms;
  logic [31:0] m_cmp, m_err, m_addr, m_data;
  logic        m_errf, m_uf;
  logic [3:0]  m_scmp, m_serr;
  logic        d1, d2;
  int          n_chk, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_cmp = 0; m_err = 0; m_addr = 0; m_data = 0;
    m_errf = 0; m_uf = 0; m_scmp = 0; m_serr = 0;
  endtask

  task automatic push_snap();
    snap_t s;
    s.cmp = m_cmp; s.err = m_err; s.errf = m_errf; s.addr = m_addr;
    s.data = m_data; s.uf = m_uf; s.scmp = m_scmp; s.serr = m_serr;
    exp_q.push_back(s);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cmp_struct_t e;
    e.addr = a; e.data = d; e.be = be;
    m_q.push_back(e);
    push_v = 1'b1; push_e = e;
    tick();
    push_v = 1'b0;
  endtask

  // Issue one read beat and record the statistics expected two edges later.
  task automatic beat(input logic [31:0] d);
    cmp_struct_t e;
    logic        mm;
    rd_valid = 1'b1; rd_data = d;
    if (m_q.size() == 0) begin
      m_uf = 1'b1;
    end else begin
      e  = m_q.pop_front();
      mm = 1'b0;
      for (int b = 0; b < 4; b++)
        if (e.be[b] && (d[b*8 +: 8] != e.data[b*8 +: 8])) mm = 1'b1;
      if (m_cmp != 32'hFFFF_FFFF) m_cmp++;
      if (m_scmp != 4'hF) m_scmp++;
      if (mm) begin
        if (m_err != 32'hFFFF_FFFF) m_err++;
        if (m_serr != 4'hF) m_serr++;
        if (!m_errf) begin
          m_addr = e.addr;
`ifdef RD_CMP_ERR_DATA_EN
          m_data = d;
`else
          m_data = 32'h0;
`endif
        end
        m_errf = 1'b1;
      end
    end
    push_snap();
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_model();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmp_cnt"}, cmp_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_err_o"}, err_f, 0);
    chk({tag, "_fe_addr"}, fe_addr, 0);
    chk({tag, "_fe_data"}, fe_data, 0);
    chk({tag, "_underflow"}, uf, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    srst_n = 1'b0; rd_valid = 1'b0; rd_data = '0; start = 1'b0;
    push_v = 1'b0; push_e = '0; fifo_q = '0; fifo_empty = 1'b1;
    d1 = 1'b0; d2 = 1'b0;
    clear_model();

    fork
      forever begin
        @(posedge clk);
        if (!srst_n) begin d1 = 1'b0; d2 = 1'b0; end
        else begin d2 = d1; d1 = rd_valid; end
      end
      forever begin
        @(negedge clk);
        if (d2) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_empty: got beat output, expected no pending entry (t=%0t)", $time);
          end else begin
            ms = exp_q.pop_front();
            chk("sb_cmp_cnt", cmp_cnt, ms.cmp);
            chk("sb_err_cnt", err_cnt, ms.err);
            chk("sb_err_o", err_f, ms.errf);
            chk("sb_fe_addr", fe_addr, ms.addr);
            chk("sb_fe_data", fe_data, ms.data);
            chk("sb_underflow", uf, ms.uf);
            chk("sb_sat_cmp_cnt", s_cmp_cnt, ms.scmp);
            chk("sb_sat_err_cnt", s_err_cnt, ms.serr);
            chk("sb_rdreq_match", fifo_rdreq_s, fifo_rdreq);
          end
        end
        if (fifo_empty) chk("rdreq_while_empty", fifo_rdreq, 0);
      end
    join_none

    // Reset state
    tick(); tick();
    chk("rst_rdreq", fifo_rdreq, 0);
    chk_zero("rst");
    srst_n = 1'b1;
    tick();
    chk_zero("post_rst");

    // Single matching beat
    push(32'h10, 32'hA5A5_A5A5, 4'hF);
    repeat (3) tick();
    beat(32'hA5A5_A5A5);
    tick(); tick();
    chk("single_cmp_cnt", cmp_cnt, 1);
    chk("single_err_cnt", err_cnt, 0);
    chk("single_err_o", err_f, 0);

    // Masked mismatch, then unmasked mismatch
    push(32'h20, 32'h1234_5678, 4'h3);
    push(32'h24, 32'h1234_5678, 4'hF);
    repeat (3) tick();
    beat(32'hFFFF_5678);
    beat(32'hFFFF_5678);
    tick(); tick();
    chk("mask_cmp_cnt", cmp_cnt, 3);
    chk("mask_err_cnt", err_cnt, 1);
    chk("mask_fe_addr", fe_addr, 32'h24);
`ifdef RD_CMP_ERR_DATA_EN
    chk("mask_fe_data", fe_data, 32'hFFFF_5678);
`else
    chk("mask_fe_data", fe_data, 32'h0);
`endif

    // Back-to-back: 16 preloaded entries, beats 3 and 9 corrupted
    do_start();
    chk_zero("start1");
    for (int i = 0; i < 16; i++) push(32'h100 + 4*i, 32'h1111_1111 * i, 4'hF);
    repeat (3) tick();
    for (int i = 0; i < 16; i++)
      beat((32'h1111_1111 * i) ^ ((i == 3 || i == 9) ? 32'h0000_0100 : 32'h0));
    tick(); tick();
    chk("b2b_cmp_cnt", cmp_cnt, 16);
    chk("b2b_err_cnt", err_cnt, 2);
    chk("b2b_fe_addr", fe_addr, 32'h10C);

    // Underflow
    do_start();
    beat(32'hDEAD_BEEF);
    tick(); tick();
    chk("uf_flag", uf, 1);
    chk("uf_cmp_cnt", cmp_cnt, 0);
    push(32'h30, 32'hCAFE_F00D, 4'hF);
    repeat (3) tick();
    beat(32'hCAFE_F00D);
    tick(); tick();
    chk("uf_after_cmp_cnt", cmp_cnt, 1);
    chk("uf_sticky", uf, 1);

    // start_i colliding with a mismatch reaching stage 2
    do_start();
    for (int i = 0; i < 6; i++) push(32'h200 + 4*i, 32'h0, 4'hF);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) beat(32'h1);
    tick(); tick();
    chk("pre_start_err_cnt", err_cnt, 5);
    chk("pre_start_fe_addr", fe_addr, 32'h200);
    rd_valid = 1'b1; rd_data = 32'h1;
    void'(m_q.pop_front());
    clear_model();
    push_snap();
    tick();
    rd_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_zero("start2");

    // Saturation of the 4-bit instance
    do_start();
    for (int i = 0; i < 20; i++) push(32'h300 + 4*i, 32'h0, 4'hF);
    repeat (3) tick();
    for (int i = 0; i < 20; i++) beat(32'hFFFF_FFFF);
    tick(); tick();
    chk("sat_err_cnt4", s_err_cnt, 15);
    chk("sat_cmp_cnt4", s_cmp_cnt, 15);
    chk("sat_err_cnt32", err_cnt, 20);
    chk("sat_cmp_cnt32", cmp_cnt, 20);

    // Reset mid-stream with a pop outstanding
    for (int i = 0; i < 3; i++) push(32'h400 + 4*i, 32'h0, 4'hF);
    repeat (3) tick();
    rd_valid = 1'b1; rd_data = 32'h0;
    tick();
    rd_valid = 1'b0;
    srst_n = 1'b0;
    exp_q.delete(); m_q.delete(); clear_model();
    #1;
    chk("midrst_rdreq", fifo_rdreq, 0);
    tick();
    chk_zero("midrst");
    chk("midrst_sat_cmp", s_cmp_cnt, 0);
    tick();
    srst_n = 1'b1;
    repeat (4) tick();
    chk_zero("post_midrst");
    chk("post_midrst_rdreq", fifo_rdreq, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
